// File: rtl/and_reduce_pkg.sv
// Shared types and elaboration-time helpers for the sliced AND-reduction scheduler.
package and_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices needed to cover WIDTH bits.
  function automatic int f_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Bits needed to hold a slice count in 0..nchunk.
  function automatic int f_cnt_w(input int nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/and_tree.sv
// N-input AND reduction; the single combinational datapath shared by every slice.
module and_tree #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  output logic         y
);

  assign y = &x;

endmodule

// File: rtl/and_reduce_sched.sv
// Multi-cycle AND reduction of a WIDTH-bit word through one shared CHUNK-input tree,
// one slice per cycle, with valid/ready on both sides and optional exit on a zero slice.
module and_reduce_sched
  import and_reduce_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int NCHUNK    = f_nchunk(WIDTH, CHUNK),
  localparam int CNT_W     = f_cnt_w(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [CNT_W-1:0] out_cycles
);

  localparam int K_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W = NCHUNK * CHUNK;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k;
  logic             acc;
  logic [WIDTH-1:0] data_q;
  logic [PAD_W-1:0] data_pad;
  logic [CHUNK-1:0] slice;
  logic             tree_y;
  logic             last;
  logic             load;
  logic             finish;

  // Bits beyond WIDTH in the last slice read as 1 so they never affect the result.
  always_comb begin
    data_pad              = '1;
    data_pad[WIDTH-1:0]   = data_q;
  end

  always_comb begin
    slice = '1;
    for (int s = 0; s < NCHUNK; s++) begin
      if (k == K_W'(s)) slice = data_pad[s*CHUNK +: CHUNK];
    end
  end

  and_tree #(.N(CHUNK)) u_tree (
    .x (slice),
    .y (tree_y)
  );

  assign last = (k == K_W'(NCHUNK - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last || (EARLY_EXIT && !tree_y)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= 1'b1;
      k          <= '0;
      out_y      <= 1'b0;
      out_cycles <= '0;
    end else if (load) begin
      acc <= 1'b1;
      k   <= '0;
    end else if (state_q == RUN) begin
      acc <= acc & tree_y;
      if (finish) begin
        out_y      <= acc & tree_y;
        out_cycles <= CNT_W'(k) + CNT_W'(1);
      end else begin
        k <= k + K_W'(1);
      end
    end
  end

  // NOTE: the word latch carries no reset; it is always loaded before RUN reads it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < WIDTH; j++) data_q[j] <= in_data[j];
    end
  end

endmodule

// File: tb/tb_and_reduce_sched.sv
// Self-checking bench: four scheduler configurations against a slice-count model,
// plus directed vectors with hand-computed results.
module tb_and_reduce_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [0:15] din [4];
  logic [3:0]  in_ready_v, out_valid_v, out_y_v;
  logic [2:0]  oc0, oc1;
  logic [1:0]  oc2;
  logic        oc3;

  // 0: 16/4 early exit, 1: 16/4 full run, 2: 10/4 padded, 3: 8/8 single slice
  and_reduce_sched #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
    .in_data(din[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready[0]),
    .out_y(out_y_v[0]), .out_cycles(oc0));
  and_reduce_sched #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
    .in_data(din[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready[1]),
    .out_y(out_y_v[1]), .out_cycles(oc1));
  and_reduce_sched #(.WIDTH(10), .CHUNK(4), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
    .in_data(din[2][0:9]), .out_valid(out_valid_v[2]), .out_ready(out_ready[2]),
    .out_y(out_y_v[2]), .out_cycles(oc2));
  and_reduce_sched #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1'b1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready_v[3]),
    .in_data(din[3][0:7]), .out_valid(out_valid_v[3]), .out_ready(out_ready[3]),
    .out_y(out_y_v[3]), .out_cycles(oc3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int p_w(input int i);
    return (i == 2) ? 10 : (i == 3) ? 8 : 16;
  endfunction
  function automatic int p_c(input int i);
    return (i == 3) ? 8 : 4;
  endfunction
  function automatic bit p_ee(input int i);
    return i != 1;
  endfunction
  function automatic int n_chunk(input int i);
    return (p_w(i) + p_c(i) - 1) / p_c(i);
  endfunction

  function automatic bit exp_y(input int i, input logic [0:15] d);
    for (int j = 0; j < p_w(i); j++) if (!d[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Slices visited: up to and including the first slice holding a zero, or all of them.
  function automatic int exp_cycles(input int i, input logic [0:15] d);
    for (int j = 0; j < p_w(i); j++) begin
      if (!d[j]) return p_ee(i) ? (j / p_c(i) + 1) : n_chunk(i);
    end
    return n_chunk(i);
  endfunction

  function automatic logic [2:0] dut_cycles(input int i);
    case (i)
      0:       return oc0;
      1:       return oc1;
      2:       return {1'b0, oc2};
      default: return {2'b00, oc3};
    endcase
  endfunction

  function automatic logic [0:15] rand_word();
    logic [0:15] w;
    for (int j = 0; j < 16; j++) w[j] = ($urandom_range(0, 23) != 0);
    return w;
  endfunction

  // Model: a word occupies the block for exp_cycles cycles, then waits for out_ready.
  int m_busy [4];
  bit m_pend [4];
  bit m_y    [4];
  int m_c    [4];
  int m_del  [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_busy[i] <= 0;
        m_pend[i] <= 1'b0;
      end else if (m_busy[i] == 0 && !m_pend[i]) begin
        if (in_valid[i]) begin
          m_busy[i] <= exp_cycles(i, din[i]);
          m_c[i]    <= exp_cycles(i, din[i]);
          m_y[i]    <= exp_y(i, din[i]);
        end
      end else if (m_busy[i] > 0) begin
        m_busy[i] <= m_busy[i] - 1;
        if (m_busy[i] == 1) m_pend[i] <= 1'b1;
      end else if (out_ready[i]) begin
        m_pend[i] <= 1'b0;
        m_del[i]  <= m_del[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cyc in_ready[%0d]", i), in_ready_v[i], (m_busy[i] == 0 && !m_pend[i]));
      check($sformatf("cyc out_valid[%0d]", i), out_valid_v[i], m_pend[i]);
      if (m_pend[i]) begin
        check($sformatf("cyc out_y[%0d]", i), out_y_v[i], m_y[i]);
        check($sformatf("cyc out_cycles[%0d]", i), dut_cycles(i), m_c[i]);
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input int i, input logic [0:15] d);
    int n = 0;
    din[i]      = d;
    in_valid[i] = 1'b1;
    while (!in_ready_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check($sformatf("send timeout[%0d]", i), 0, 1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    din[i]      = ~d;
  endtask

  task automatic run_directed(input string name, input int i, input logic [0:15] d,
                              input bit ey, input int ec);
    int lat = 0;
    send(i, d);
    while (!out_valid_v[i] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, ec);
    check({name, " out_y"}, out_y_v[i], ey);
    check({name, " out_cycles"}, dut_cycles(i), ec);
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    check({name, " back to idle"}, in_ready_v[i], 1);
  endtask

  logic [0:15] ones, d;
  int sent   [4];
  int del0   [4];
  int target [4];
  int guard;

  initial begin
    ones      = '1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 4; i++) din[i] = '1;

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset in_ready[%0d]", i), in_ready_v[i], 1);
      check($sformatf("reset out_valid[%0d]", i), out_valid_v[i], 0);
      check($sformatf("reset out_y[%0d]", i), out_y_v[i], 0);
      check($sformatf("reset out_cycles[%0d]", i), dut_cycles(i), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    d = ones; d[5] = 1'b0;
    check("model pin early", exp_cycles(0, d), 2);
    check("model pin full", exp_cycles(1, d), 4);

    run_directed("all ones 16/4", 0, ones, 1'b1, 4);
    run_directed("bit5 early", 0, d, 1'b0, 2);
    run_directed("bit5 no early", 1, d, 1'b0, 4);
    d = ones; d[15] = 1'b0;
    run_directed("bit15 early", 0, d, 1'b0, 4);
    run_directed("pad ones 10/4", 2, ones, 1'b1, 3);
    d = ones; d[9] = 1'b0;
    run_directed("pad bit9", 2, d, 1'b0, 3);
    d = ones; d[0] = 1'b0;
    run_directed("pad bit0", 2, d, 1'b0, 1);
    run_directed("single ones 8/8", 3, ones, 1'b1, 1);
    d = ones; d[7] = 1'b0;
    run_directed("single bit7", 3, d, 1'b0, 1);

    // Backpressure: result must hold and new words must be refused.
    d = ones; d[13] = 1'b0;
    send(0, d);
    guard = 0;
    while (!out_valid_v[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid[0] = 1'b1;
    din[0]      = ones;
    repeat (5) begin
      @(negedge clk);
      check("hold out_valid", out_valid_v[0], 1);
      check("hold out_y", out_y_v[0], 0);
      check("hold out_cycles", dut_cycles(0), 4);
      check("hold in_ready", in_ready_v[0], 0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("hold release idle", in_ready_v[0], 1);

    // Reset in the second RUN cycle drops the word.
    send(0, ones);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-run reset in_ready", in_ready_v[0], 1);
    check("mid-run reset out_valid", out_valid_v[0], 0);
    out_ready[0] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("mid-run reset no output", out_valid_v[0], 0);
    end
    out_ready[0] = 1'b0;

    // Random traffic on all four instances.
    target = '{1000, 300, 300, 300};
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      del0[i] = m_del[i];
    end
    guard = 0;
    while ((sent[0] < target[0] || sent[1] < target[1] || sent[2] < target[2] ||
            sent[3] < target[3]) && guard < 40000) begin
      for (int i = 0; i < 4; i++) begin
        if (sent[i] < target[i] && $urandom_range(0, 3) != 0) begin
          in_valid[i] = 1'b1;
          din[i]      = rand_word();
        end else begin
          in_valid[i] = 1'b0;
        end
        if (in_valid[i] && in_ready_v[i]) sent[i]++;
        out_ready[i] = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = '0;
    out_ready = '1;
    guard = 0;
    while ((m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3] || m_busy[0] != 0 ||
            m_busy[1] != 0 || m_busy[2] != 0 || m_busy[3] != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("random delivered[%0d]", i), m_del[i] - del0[i], target[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
